// File: rtl/timer_counter.sv
// Prescaled up/down timer-counter with IDLE/RUN/DONE control and a one-cycle terminal tick.
// Latency: count/busy/done are registered; tick is combinational from the registered state; no backpressure.
// The optional saturating tick counter (wrap_cnt) is enabled by defining TIMER_COUNTER_WRAP_STAT_EN.
module timer_counter #(
    parameter int COUNTER_SIZE  = 16,
    parameter int PRESCALE_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     inc,
    input  logic                     auto_reload,
    input  logic [COUNTER_SIZE-1:0]  cnt_goal,
    input  logic [PRESCALE_SIZE-1:0] prescale,
    output logic [COUNTER_SIZE-1:0]  count,
    output logic                     tick,
    output logic                     busy,
    output logic                     done
`ifdef TIMER_COUNTER_WRAP_STAT_EN
    ,
    output logic [7:0]               wrap_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COUNTER_SIZE-1:0]  CNT_ONE = 1;
    localparam logic [PRESCALE_SIZE-1:0] PSC_ONE = 1;

    state_t                   r_state;
    logic [COUNTER_SIZE-1:0]  r_count;
    logic [PRESCALE_SIZE-1:0] r_psc_cnt;
    logic                     r_dir_up;
    logic                     r_reload;
    logic [COUNTER_SIZE-1:0]  r_goal;
    logic [PRESCALE_SIZE-1:0] r_psc;
    logic                     r_busy;
    logic                     r_done;

    logic [COUNTER_SIZE-1:0]  w_init;
    logic [COUNTER_SIZE-1:0]  w_term;
    logic                     w_step;
    logic                     w_at_term;
    logic                     w_run;
    logic                     w_cmd;

    assign w_init    = r_dir_up ? '0 : r_goal;
    assign w_term    = r_dir_up ? r_goal : '0;
    assign w_step    = (r_psc_cnt == r_psc);
    assign w_at_term = (r_count == w_term);
    assign w_run     = (r_state == RUN);
    assign w_cmd     = clear | stop | start;

    // Any command pre-empts the step, so a terminal step that coincides with one is not reported.
    assign tick  = w_run & w_step & w_at_term & ~w_cmd;
    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_psc_cnt <= '0;
            r_dir_up  <= 1'b1;
            r_reload  <= 1'b0;
            r_goal    <= '0;
            r_psc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (clear) begin
            r_count   <= w_init;
            r_psc_cnt <= '0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (stop) begin
            if (w_run) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end
        end else if (start) begin
            r_dir_up  <= inc;
            r_reload  <= auto_reload;
            r_goal    <= cnt_goal;
            r_psc     <= prescale;
            r_count   <= inc ? '0 : cnt_goal;
            r_psc_cnt <= '0;
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else if (w_run) begin
            if (w_step) begin
                r_psc_cnt <= '0;
                if (w_at_term) begin
                    if (r_reload) begin
                        r_count <= w_init;
                    end else begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end else begin
                    r_count <= r_dir_up ? (r_count + CNT_ONE) : (r_count - CNT_ONE);
                end
            end else begin
                r_psc_cnt <= r_psc_cnt + PSC_ONE;
            end
        end
    end

`ifdef TIMER_COUNTER_WRAP_STAT_EN
    logic [7:0] r_wrap_cnt;

    assign wrap_cnt = r_wrap_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wrap_cnt <= 8'd0;
        end else if (clear || (start && !stop)) begin
            r_wrap_cnt <= 8'd0;
        end else if (tick && (r_wrap_cnt != 8'hFF)) begin
            r_wrap_cnt <= r_wrap_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_timer_counter.sv
// Randomised bench for timer_counter: a position-based model predicts count/tick/busy/done
// (and wrap_cnt when TIMER_COUNTER_WRAP_STAT_EN is defined) every cycle.
module tb_timer_counter;

    localparam int CS = 16;
    localparam int PS = 8;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic          clk;
    logic          n_rst;
    logic          start, stop, clear, inc, auto_reload;
    logic [CS-1:0] cnt_goal;
    logic [PS-1:0] prescale;
    logic [CS-1:0] count;
    logic          tick, busy, done;
`ifdef TIMER_COUNTER_WRAP_STAT_EN
    logic [7:0]    wrap_cnt;
`endif

    timer_counter #(.COUNTER_SIZE(CS), .PRESCALE_SIZE(PS)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .stop(stop), .clear(clear),
        .inc(inc), .auto_reload(auto_reload), .cnt_goal(cnt_goal), .prescale(prescale),
        .count(count), .tick(tick), .busy(busy), .done(done)
`ifdef TIMER_COUNTER_WRAP_STAT_EN
        , .wrap_cnt(wrap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: in RUN the count is a pure function of how many RUN cycles elapsed since start.
    int      m_state;
    longint  m_p;
    longint  m_count;
    longint  m_goal, m_psc;
    bit      m_dir_up, m_rel, m_tick;
    int      m_wrap;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint run_count();
        longint period, s;
        period = (m_goal + 1) * (m_psc + 1);
        s = (m_p % period) / (m_psc + 1);
        return m_dir_up ? s : (m_goal - s);
    endfunction

    function automatic bit tick_now();
        longint period;
        period = (m_goal + 1) * (m_psc + 1);
        return (m_state == S_RUN) && ((m_p % period) == period - 1) && !clear && !stop && !start;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_p = 0; m_count = 0; m_goal = 0; m_psc = 0;
        m_dir_up = 1'b1; m_rel = 1'b0; m_wrap = 0;
    endtask

    task automatic check_all();
        m_tick = tick_now();
        chk("count", longint'(count), (m_state == S_RUN) ? run_count() : m_count);
        chk("tick", longint'(tick), longint'(m_tick));
        chk("busy", longint'(busy), longint'(m_state == S_RUN));
        chk("done", longint'(done), longint'(m_state == S_DONE));
`ifdef TIMER_COUNTER_WRAP_STAT_EN
        chk("wrap_cnt", longint'(wrap_cnt), longint'(m_wrap));
`endif
    endtask

    task automatic model_update();
        if (clear) begin
            m_count = m_dir_up ? 0 : m_goal;
            m_state = S_IDLE;
            m_wrap  = 0;
        end else if (stop) begin
            if (m_state == S_RUN) begin
                m_count = run_count();
                m_state = S_IDLE;
            end
        end else if (start) begin
            m_dir_up = inc; m_rel = auto_reload;
            m_goal = longint'(cnt_goal); m_psc = longint'(prescale);
            m_p = 0; m_state = S_RUN; m_wrap = 0;
        end else if (m_state == S_RUN) begin
            if (m_tick) begin
                if (m_wrap < 255) m_wrap++;
                if (!m_rel) begin
                    m_count = run_count();
                    m_state = S_DONE;
                end
            end
            m_p++;
        end
    endtask

    task automatic cyc(input logic st, input logic sp, input logic cl, input logic in_,
                       input logic ar, input int goal, input int psc);
        @(negedge clk);
        start = st; stop = sp; clear = cl; inc = in_; auto_reload = ar;
        cnt_goal = CS'(goal); prescale = PS'(psc);
        #1;
        check_all();
        model_update();
    endtask

    // Idle cycle whose data inputs are random, to show they are ignored while running.
    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 255)));
    endtask

    initial begin
        int ticks, first_t, last_t;
        bit cnt_ok;
        start = 0; stop = 0; clear = 0; inc = 0; auto_reload = 0;
        cnt_goal = '0; prescale = '0;
        n_rst = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Up one-shot, goal=3, psc=0.
        cyc(1, 0, 0, 1, 0, 3, 0);
        for (int k = 0; k <= 3; k++) begin
            idle_cyc();
            chk("up_seq", longint'(count), k);
            chk("up_tick", longint'(tick), (k == 3) ? 1 : 0);
        end
        idle_cyc();
        chk("up_done", longint'(done), 1);
        chk("up_busy", longint'(busy), 0);
        chk("up_hold", longint'(count), 3);

        // Down auto-reload, goal=2, psc=1: tick every 6 cycles.
        cyc(1, 0, 0, 0, 1, 2, 1);
        ticks = 0; first_t = -1; last_t = -1;
        for (int k = 0; k < 18; k++) begin
            idle_cyc();
            if (tick) begin
                ticks++;
                if (first_t < 0) first_t = k;
                last_t = k;
            end
        end
        chk("dn_ticks", ticks, 3);
        chk("dn_first", first_t, 5);
        chk("dn_gap", last_t - first_t, 12);
        chk("dn_busy", longint'(busy), 1);

        // Stop at count=5, then clear+start together.
        cyc(1, 0, 0, 1, 1, 10, 0);
        repeat (5) idle_cyc();
        cyc(0, 1, 0, 1, 1, 10, 0);
        chk("stop_at", longint'(count), 5);
        idle_cyc();
        chk("stop_hold", longint'(count), 5);
        chk("stop_busy", longint'(busy), 0);
        cyc(1, 0, 1, 0, 1, 7, 0);
        idle_cyc();
        chk("clr_win_cnt", longint'(count), 0);
        chk("clr_win_busy", longint'(busy), 0);

        // goal=0, psc=3, auto-reload: tick every 4 cycles, count stays 0.
        cyc(1, 0, 0, 1, 1, 0, 3);
        ticks = 0; cnt_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            idle_cyc();
            if (tick) ticks++;
            if (count != '0) cnt_ok = 1'b0;
        end
        chk("g0_ticks", ticks, 4);
        chk("g0_count", longint'(cnt_ok), 1);

        // 300 ticks with goal=0, psc=0 to saturate the statistics counter.
        cyc(1, 0, 0, 1, 1, 0, 0);
        repeat (300) idle_cyc();
`ifdef TIMER_COUNTER_WRAP_STAT_EN
        chk("wrap_sat", longint'(wrap_cnt), 255);
        cyc(1, 0, 0, 1, 1, 0, 0);
        idle_cyc();
        chk("wrap_start", longint'(wrap_cnt), 0);
`endif

        // Reset mid-run.
        cyc(1, 0, 0, 1, 1, 9, 2);
        repeat (7) idle_cyc();
        @(negedge clk);
        start = 0; stop = 0; clear = 0;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) cyc(0, 0, 0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 9)), 0);
        chk("rst_idle", longint'(busy), 0);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            logic st, sp, cl;
            int g, p;
            st = ($urandom_range(0, 29) == 0);
            sp = ($urandom_range(0, 59) == 0);
            cl = ($urandom_range(0, 89) == 0);
            g  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6));
            p  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            cyc(st, sp, cl, 1'($urandom), 1'($urandom), g, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
